wb_grf: RTL and testbench

WB_GRF -- requirements
Module: wb_grf

---
 rtl/wb_grf_if.sv | 37 +++
 rtl/wb_grf.sv | 124 ++++++++++++
 tb/tb_wb_grf.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/wb_grf_if.sv
`default_nettype none
// ============================================================================
// Module  : wb_grf_if
// Purpose : Bus bundle between the W stage / D stage and the register file:
//           write-back stage inputs, two read ports and the write-back
//           (forwarding) outputs.
// Revision: 1.0  initial release
// ============================================================================
interface wb_grf_if;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic [31:0] in_ext;
    logic [31:0] in_alu_out;
    logic [31:0] in_dm_out;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    // Pipeline side: drives W-stage results and read addresses
    modport master (
        output in_pc, in_instr, in_ext, in_alu_out, in_dm_out,
        output rs_addr, rt_addr,
        input  rs_data, rt_data, wb_we, wb_addr, wb_data
    );

    // Register file side
    modport slave (
        input  in_pc, in_instr, in_ext, in_alu_out, in_dm_out,
        input  rs_addr, rt_addr,
        output rs_data, rt_data, wb_we, wb_addr, wb_data
    );
endinterface
`default_nettype wire

// File: rtl/wb_grf.sv
`default_nettype none
// ============================================================================
// Module  : wb_grf
// Purpose : Write-back stage decode plus 32x32 general register file with
//           two combinational read ports and a retired-instruction counter.
//           Optional macro WB_BYPASS_EN: read ports forward the write-back
//           value in the same cycle the write is presented.
// Revision: 1.0  initial release
// ============================================================================
module wb_grf #(
    parameter int CNT_W = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    wb_grf_if.slave               bus,
    output      logic [CNT_W-1:0] retired
);

    localparam logic [5:0] c_OP_SPECIAL = 6'h00;
    localparam logic [5:0] c_OP_JAL     = 6'h03;
    localparam logic [5:0] c_OP_ORI     = 6'h0D;
    localparam logic [5:0] c_OP_LUI     = 6'h0F;
    localparam logic [5:0] c_OP_LW      = 6'h23;
    localparam logic [5:0] c_FN_ADDU    = 6'h21;
    localparam logic [5:0] c_FN_SUBU    = 6'h23;

    logic [5:0]       w_op;
    logic [5:0]       w_funct;
    logic             w_wr;
    logic [4:0]       w_dest;
    logic [31:0]      w_data;
    logic [31:0]      w_rs_stored;
    logic [31:0]      w_rt_stored;
    logic [31:0]      r_regs [0:31];
    logic [CNT_W-1:0] r_retired;
    logic             w_unused_instr;

    assign w_op           = bus.in_instr[31:26];
    assign w_funct        = bus.in_instr[5:0];
    assign w_unused_instr = ^{bus.in_instr[25:21], bus.in_instr[10:6]};

    // Decode the W-stage instruction into destination and write data
    always_comb begin
        w_wr   = 1'b0;
        w_dest = 5'd0;
        w_data = 32'd0;
        case (w_op)
            c_OP_SPECIAL: begin
                if (w_funct == c_FN_ADDU || w_funct == c_FN_SUBU) begin
                    w_wr   = 1'b1;
                    w_dest = bus.in_instr[15:11];
                    w_data = bus.in_alu_out;
                end
            end
            c_OP_ORI: begin
                w_wr   = 1'b1;
                w_dest = bus.in_instr[20:16];
                w_data = bus.in_alu_out;
            end
            c_OP_LUI: begin
                w_wr   = 1'b1;
                w_dest = bus.in_instr[20:16];
                w_data = bus.in_ext;
            end
            c_OP_LW: begin
                w_wr   = 1'b1;
                w_dest = bus.in_instr[20:16];
                w_data = bus.in_dm_out;
            end
            c_OP_JAL: begin
                w_wr   = 1'b1;
                w_dest = 5'd31;
                w_data = bus.in_pc + 32'd8;
            end
            default: begin
                w_wr   = 1'b0;
            end
        endcase
    end

    // A write to $0 is no write at all; address/data are zeroed with it so
    // forwarding logic downstream can never match on a dead value.
    assign bus.wb_we   = w_wr && (w_dest != 5'd0);
    assign bus.wb_addr = bus.wb_we ? w_dest : 5'd0;
    assign bus.wb_data = bus.wb_we ? w_data : 32'd0;

    // Register array: async clear, write on clock edge when write-back enabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else if (bus.wb_we) begin
            r_regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Count every non-bubble instruction leaving the W stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retired <= '0;
        end else if (bus.in_instr != 32'd0) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    assign retired = r_retired;

    // $0 is hardwired; entry 0 of the array is never written anyway
    assign w_rs_stored = (bus.rs_addr == 5'd0) ? 32'd0 : r_regs[bus.rs_addr];
    assign w_rt_stored = (bus.rt_addr == 5'd0) ? 32'd0 : r_regs[bus.rt_addr];

`ifdef WB_BYPASS_EN
    // Same-cycle forwarding of the value being written back
    assign bus.rs_data = (bus.wb_we && bus.rs_addr == bus.wb_addr) ? bus.wb_data : w_rs_stored;
    assign bus.rt_data = (bus.wb_we && bus.rt_addr == bus.wb_addr) ? bus.wb_data : w_rt_stored;
`else
    // Stored values only; a new value shows up after its write edge
    assign bus.rs_data = w_rs_stored;
    assign bus.rt_data = w_rt_stored;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_grf.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_grf
// Purpose : Directed self-checking bench for wb_grf (CNT_W = 4).
// Revision: 1.0  initial release
// ============================================================================
module tb_wb_grf;

    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic [CNT_W-1:0] retired;
    int               n_vec;
    int               n_miss;
    int               exp_ret;

    wb_grf_if bus ();

    wb_grf #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .retired (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, tracking the expected retired count
    task automatic step();
        if (!reset && bus.in_instr != 32'd0) exp_ret = (exp_ret + 1) % 16;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.rs_addr = a;
        bus.rt_addr = a;
        #1;
        chk({tag, "_rs"}, bus.rs_data, exp);
        chk({tag, "_rt"}, bus.rt_data, exp);
    endtask

    task automatic wb_chk(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        #1;
        chk({tag, "_we"}, {31'd0, bus.wb_we}, {31'd0, we});
        chk({tag, "_addr"}, {27'd0, bus.wb_addr}, {27'd0, a});
        chk({tag, "_data"}, bus.wb_data, d);
    endtask

    initial begin
        n_vec   = 0;
        n_miss  = 0;
        exp_ret = 0;
        reset   = 1'b0;
        bus.in_pc      = 32'd0;
        bus.in_instr   = 32'd0;
        bus.in_ext     = 32'd0;
        bus.in_alu_out = 32'd0;
        bus.in_dm_out  = 32'd0;
        bus.rs_addr    = 5'd0;
        bus.rt_addr    = 5'd0;

        // Asynchronous reset pulse before the first clock edge
        #1 reset = 1'b1;
        #1 reset = 1'b0;
        for (int i = 0; i < 32; i += 5) rd_chk($sformatf("rst_r%0d", i), i[4:0], 32'd0);
        rd_chk("rst_r31", 5'd31, 32'd0);
        chk("rst_retired", {28'd0, retired}, 32'd0);
        @(posedge clk);
        #1;

        // ori $5,$0,0x1234
        bus.in_instr = 32'h3405_1234; bus.in_alu_out = 32'h0000_1234;
        wb_chk("ori", 1'b1, 5'd5, 32'h0000_1234);
        step();
        bus.in_instr = 32'd0;
        rd_chk("ori_r5", 5'd5, 32'h0000_1234);
        chk("ori_retired", {28'd0, retired}, 32'd1);

        // jal from 0x3008 links to 0x3010
        bus.in_instr = 32'h0C00_0000; bus.in_pc = 32'h0000_3008;
        wb_chk("jal", 1'b1, 5'd31, 32'h0000_3010);
        step();
        bus.in_instr = 32'd0;
        rd_chk("jal_r31", 5'd31, 32'h0000_3010);

        // jal link wraps modulo 2^32
        bus.in_instr = 32'h0C00_0000; bus.in_pc = 32'hFFFF_FFFC;
        wb_chk("jal_wrap", 1'b1, 5'd31, 32'h0000_0004);
        step();

        // addu $0 : suppressed write
        bus.in_instr = 32'h0022_0021; bus.in_alu_out = 32'hFFFF_FFFF;
        wb_chk("addu_r0", 1'b0, 5'd0, 32'd0);
        step();
        bus.in_instr = 32'd0;
        rd_chk("addu_r0_rd", 5'd0, 32'd0);

        // addu $3, subu $4, lui $6
        bus.in_instr = 32'h0022_1821; bus.in_alu_out = 32'hAAAA_5555;
        wb_chk("addu", 1'b1, 5'd3, 32'hAAAA_5555);
        step();
        bus.in_instr = 32'h0022_2023; bus.in_alu_out = 32'h1111_2222;
        wb_chk("subu", 1'b1, 5'd4, 32'h1111_2222);
        step();
        bus.in_instr = 32'h3C06_0000; bus.in_ext = 32'hABCD_0000; bus.in_alu_out = 32'h0BAD_0BAD;
        wb_chk("lui", 1'b1, 5'd6, 32'hABCD_0000);
        step();
        bus.in_instr = 32'd0;
        rd_chk("addu_r3", 5'd3, 32'hAAAA_5555);
        rd_chk("subu_r4", 5'd4, 32'h1111_2222);
        rd_chk("lui_r6", 5'd6, 32'hABCD_0000);

        // Non-writing encodings: sw, beq, jr, undefined funct
        bus.in_instr = 32'hAC07_0000; wb_chk("sw", 1'b0, 5'd0, 32'd0); step();
        bus.in_instr = 32'h1000_0000; wb_chk("beq", 1'b0, 5'd0, 32'd0); step();
        bus.in_instr = 32'h03E0_0008; wb_chk("jr", 1'b0, 5'd0, 32'd0); step();
        bus.in_instr = 32'h0022_1822; wb_chk("undef", 1'b0, 5'd0, 32'd0); step();
        bus.in_instr = 32'd0;
        rd_chk("nowr_r7", 5'd7, 32'd0);
        rd_chk("nowr_r3", 5'd3, 32'hAAAA_5555);
        chk("retired_mid", {28'd0, retired}, exp_ret[31:0]);

        // lw $7 with same-cycle read of $7
        bus.in_instr = 32'h8C07_0000; bus.in_dm_out = 32'hDEAD_BEEF;
        wb_chk("lw", 1'b1, 5'd7, 32'hDEAD_BEEF);
`ifdef WB_BYPASS_EN
        rd_chk("lw_same", 5'd7, 32'hDEAD_BEEF);
`else
        rd_chk("lw_same", 5'd7, 32'd0);
`endif
        step();
        bus.in_instr = 32'd0;
        rd_chk("lw_after", 5'd7, 32'hDEAD_BEEF);

        // Reset held across a write edge: write lost, counter cleared
        bus.in_instr = 32'h3408_0055; bus.in_alu_out = 32'h0000_0055;
        reset = 1'b1;
        #1;
        chk("rst_async_ret", {28'd0, retired}, 32'd0);
        exp_ret = 0;
        step();
        reset = 1'b0;
        bus.in_instr = 32'd0;
        #1;
        rd_chk("rstw_r8", 5'd8, 32'd0);
        rd_chk("rstw_r5", 5'd5, 32'd0);
        chk("rstw_retired", {28'd0, retired}, 32'd0);

        // 16 non-zero instructions with nops between: 4-bit counter wraps
        for (int i = 0; i < 16; i++) begin
            bus.in_instr = 32'hAC07_0000;
            step();
            chk($sformatf("wrap_i%0d", i), {28'd0, retired}, (i + 1) % 16);
            bus.in_instr = 32'd0;
            step();
            chk($sformatf("wrap_nop%0d", i), {28'd0, retired}, (i + 1) % 16);
        end
        chk("wrap_model", {28'd0, retired}, exp_ret[31:0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
